// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver.
// Captures a Gray-coded 16-bit value, converts it to binary and scans the
// four hex digits with an all-off dead time before each digit. The shown
// value is swapped only at the frame boundary so a digit never tears.
module seg7_scan_driver #(
    parameter int unsigned REFRESH = 100000,
    parameter int unsigned BLANK   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] gray_in,
    input  logic        load,
    input  logic [3:0]  dp_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    typedef enum logic {
        S_BLANK,
        S_DRIVE
    } state_t;

    localparam logic [27:0] BLANK_LAST   = 28'(BLANK - 1);
    localparam logic [27:0] REFRESH_LAST = 28'(REFRESH - 1);

    state_t      state, state_nx;
    logic [1:0]  digit, digit_nx;
    logic [27:0] cnt, cnt_nx;
    logic        boundary;

    logic [15:0] shadow;
    logic [15:0] disp;
    logic        pending;

    logic [3:0]  an_nx;
    logic [6:0]  seg_nx;
    logic        dp_nx;
    logic        frame_done_nx;

    function automatic logic [15:0] gray2bin(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int unsigned k = 1; k < 16; k++) begin
            b[15-k] = b[16-k] ^ g[15-k];
        end
        return b;
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Scan FSM registers and the registered outputs, all on one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_BLANK;
            digit      <= '0;
            cnt        <= '0;
            an         <= '1;
            seg        <= '1;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            digit      <= digit_nx;
            cnt        <= cnt_nx;
            an         <= an_nx;
            seg        <= seg_nx;
            dp         <= dp_nx;
            frame_done <= frame_done_nx;
        end
    end

    // Next state plus next output values; outputs are decoded from the
    // next state so they line up with the state register.
    always_comb begin
        state_nx      = state;
        digit_nx      = digit;
        cnt_nx        = cnt + 28'd1;
        boundary      = 1'b0;
        an_nx         = '1;
        seg_nx        = '1;
        dp_nx         = 1'b1;
        frame_done_nx = 1'b0;

        if (!enable) begin
            state_nx = S_BLANK;
            digit_nx = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nx = S_DRIVE;
                        cnt_nx   = '0;
                    end
                end
                S_DRIVE: begin
                    if (cnt == REFRESH_LAST) begin
                        state_nx = S_BLANK;
                        cnt_nx   = '0;
                        digit_nx = digit + 2'd1;
                        boundary = (digit == 2'd3);
                    end
                end
                default: begin
                    state_nx = S_BLANK;
                    cnt_nx   = '0;
                end
            endcase
        end

        frame_done_nx = boundary;
        if (state_nx == S_DRIVE) begin
            an_nx  = ~(4'b0001 << digit_nx);
            seg_nx = hex7(disp[{digit_nx, 2'b00} +: 4]);
            dp_nx  = ~dp_en[digit_nx];
        end
    end

    // Shadow capture and tear-free display update at the frame boundary.
    // A load on the boundary cycle keeps pending set: the display takes the
    // old shadow while the new value waits for the following boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else begin
            if (boundary && pending) begin
                disp <= gray2bin(shadow);
            end
            if (load) begin
                shadow  <= gray_in;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: the driver advances a frame-position
// reference model at every edge and queues the expected outputs; a monitor
// pops and compares one entry per cycle.
module tb_seg7_scan_driver;

    localparam int R  = 4;
    localparam int B  = 2;
    localparam int DL = B + R;
    localparam int F  = 4 * DL;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] gray_in = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_en = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    seg7_scan_driver #(.REFRESH(R), .BLANK(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .gray_in    (gray_in),
        .load       (load),
        .dp_en      (dp_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // reference model state
    int          pos = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_disp = '0;
    bit          m_pending = 1'b0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam exp_t OFF = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};

    // Gray to binary as a prefix XOR of right shifts.
    function automatic logic [15:0] g2b(input logic [15:0] g);
        logic [15:0] b = '0;
        for (int k = 0; k < 16; k++) b ^= (g >> k);
        return b;
    endfunction

    // One clock edge of the reference model using the inputs now applied.
    task automatic model_edge();
        exp_t e;
        bit bnd;
        int d, ph;
        e = OFF;
        if (reset) begin
            pos = 0; m_shadow = '0; m_disp = '0; m_pending = 1'b0;
        end else if (!enable) begin
            pos = 0;
            if (load) begin m_shadow = gray_in; m_pending = 1'b1; end
        end else begin
            bnd = (pos == F - 1);
            if (bnd && m_pending) m_disp = g2b(m_shadow);
            if (load) begin m_shadow = gray_in; m_pending = 1'b1; end
            else if (bnd) m_pending = 1'b0;
            pos = (pos + 1) % F;
            d  = pos / DL;
            ph = pos % DL;
            e.fd = bnd;
            if (ph >= B) begin
                e.an  = 4'hF & ~(4'(1) << d);
                e.seg = hex_tab[(m_disp >> (4 * d)) & 16'hF];
                e.dp  = ~dp_en[d];
            end
        end
        q.push_back(e);
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the current cycle lies in [lo, hi] of the frame.
    task automatic wait_pos(input int lo, input int hi);
        int n = 0;
        while (!(pos >= lo && pos <= hi) && n < 3 * F) begin
            tick();
            n++;
        end
        if (n >= 3 * F) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_pos: position %0d never reached %0d..%0d", pos, lo, hi);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        gray_in = v; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Monitor: compare once per cycle, just after the active edge.
    initial begin
        exp_t e, got;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                got = '{an: an, seg: seg, dp: dp, fd: frame_done};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                             cyc, got.an, got.seg, got.dp, got.fd, e.an, e.seg, e.dp, e.fd);
                end
            end
        end
    end

    initial begin
        int en_off;
        @(negedge clk);
        ticks(3);
        reset = 1'b0;

        // idle scan, all zeros, frame_done every F cycles
        ticks(2 * F + 6);

        // load mid-frame: digit0 becomes 2 only after the boundary
        wait_pos(8, 8);
        do_load(16'h0003);
        ticks(2 * F);

        // FFFF, then a load on the boundary while still pending
        wait_pos(5, 5);
        do_load(16'h8000);
        wait_pos(F - 1, F - 1);
        do_load(16'h0001);
        ticks(3 * F);

        // decimal point on digit 2 only
        dp_en = 4'b0100;
        ticks(F + 3);
        dp_en = 4'b1011;
        ticks(F);

        // enable drop during DRIVE of digit 2
        wait_pos(2 * DL + B + 1, 2 * DL + B + 1);
        enable = 1'b0;
        do_load(16'h1234);
        ticks(3);
        enable = 1'b1;
        ticks(2 * F + 2);

        // reset during DRIVE of digit 1 after a load
        do_load(16'hBEEF);
        wait_pos(DL + B + 1, DL + B + 1);
        reset = 1'b1;
        #1;
        vectors++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_immediate: got an=%b seg=%b dp=%b fd=%b, want 1111 1111111 1 0",
                     an, seg, dp, frame_done);
        end
        ticks(2);
        reset = 1'b0;
        ticks(2 * F + 4);

        // randomized traffic
        en_off = 0;
        for (int i = 0; i < 1500; i++) begin
            gray_in = 16'($urandom);
            load = ($urandom_range(0, 15) == 0);
            if (i % 7 == 0) dp_en = 4'($urandom);
            if (en_off > 0) begin
                en_off--;
                enable = (en_off == 0);
            end else if ($urandom_range(0, 149) == 0) begin
                en_off = $urandom_range(1, 8);
                enable = 1'b0;
            end
            reset = ($urandom_range(0, 699) == 0);
            tick();
        end
        load = 1'b0; reset = 1'b0; enable = 1'b1;
        ticks(F);

        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter REFRESH, default 100000, meaning the number of cycles each digit is driven (1 ms at 100 MHz); legal range is 1 or more.
REQ-002 The block SHALL have parameter BLANK, default 1000, meaning the number of all-off dead-time cycles before each digit (anti-ghosting); legal range is 1 or more.
REQ-003 The block SHALL have port clk  input  1  system clock.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port enable  input  1  scanning enable; low forces the display dark.
REQ-006 The block SHALL have port gray_in  input  16  Gray-coded value to display.
REQ-007 The block SHALL have port load  input  1  single-cycle strobe that captures gray_in.
REQ-008 The block SHALL have port dp_en  input  4  decimal-point request per digit, active-high.
REQ-009 The block SHALL have port an  output  4  digit anodes, active-low; an[d] selects digit d.
REQ-010 The block SHALL have port seg  output  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
REQ-011 The block SHALL have port dp  output  1  decimal point, active-low.
REQ-012 The block SHALL have port frame_done  output  1  one-cycle pulse marking the end of a full 4-digit scan.

Function
REQ-013 On a cycle with load=1, the block SHALL capture gray_in into a shadow register and set a pending flag.
REQ-014 The block SHALL convert shadow to binary as follows: b[15]=g[15]; b[i]=b[i+1]^g[i] for i=14..0.
REQ-015 The displayed register SHALL update only at the frame boundary (the last DRIVE cycle of digit 3), and only when pending=1. The update loads the converted shadow, which avoids tearing.
REQ-016 If load coincides with the frame boundary, the displayed register SHALL take the previous shadow contents, the shadow SHALL take the new gray_in, and pending SHALL stay 1 so the new value applies at the next boundary.
REQ-017 Multiple loads within one frame SHALL overwrite the shadow; only the last load is displayed.
REQ-018 The FSM SHALL have states BLANK and DRIVE, a 2-bit digit index (0..3), and a 28-bit cycle counter.
REQ-019 BLANK SHALL hold an=4'b1111, seg=7'h7F and dp=1 for exactly BLANK cycles, then move to DRIVE with the counter cleared.
REQ-020 DRIVE SHALL hold an[d]=0 (other anodes at 1), seg=hex pattern of display nibble d, and dp=~dp_en[d] for exactly REFRESH cycles, then move to BLANK with d=d+1 (mod 4).
REQ-021 The nibble mapping SHALL be: digit 0 = bits[3:0], digit 1 = [7:4], digit 2 = [11:8], digit 3 = [15:12].
REQ-022 The frame period SHALL be exactly 4*(BLANK+REFRESH) cycles, with digit order 0,1,2,3,0,...
REQ-023 frame_done SHALL be 1 for exactly one cycle, the cycle after leaving DRIVE of digit 3, and 0 otherwise.
REQ-024 an, seg, dp and frame_done SHALL be registered (no combinational path from inputs), and they SHALL change on the same clock edge as the FSM state.
REQ-025 The hex table (active-low {g..a}) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-026 While enable=0, the block SHALL force state BLANK, digit 0, counter 0 and all outputs off. load SHALL still be captured, and the boundary update SHALL NOT occur.
REQ-027 When enable rises, scanning SHALL restart at BLANK of digit 0, with no partial digit shown.
REQ-028 dp_en SHALL be sampled live every cycle during DRIVE (no latching).

Reset
REQ-029 Reset assertion SHALL immediately force an=4'b1111, seg=7'h7F, dp=1 and frame_done=0.
REQ-030 Reset SHALL also clear the state to BLANK, digit to 0, counter to 0, shadow and displayed registers to 0, and pending to 0.
REQ-031 Reset mid-frame SHALL abandon the scan with no frame_done pulse; after release, scanning SHALL start at BLANK of digit 0.
REQ-032 After release, the first DRIVE SHALL begin BLANK cycles later and SHALL show digit 0 = 0 (seg=1000000).

Verification (REFRESH=4, BLANK=2, enable=1)
REQ-033 Test: release reset with no load -> per digit, 2 cycles an=1111 then 4 cycles an=1110/1101/1011/0111 with seg=1000000; frame_done pulses every 24 cycles.
REQ-034 Test: load gray_in=16'h0003 mid-frame -> digits 0..3 stay 0 until the boundary; the next frame shows digit0=2 (0100100) and digits 1-3=0.
REQ-035 Test: load 16'h8000 -> display FFFF (seg=0001110 on all digits). Then load 16'h0001 exactly on the boundary cycle -> that frame shows FFFF and the following frame shows 0001.
REQ-036 Test: dp_en=4'b0100 -> dp=0 only while an=1011; dp=1 during BLANK cycles and during other digits.
REQ-037 Test: drop enable during DRIVE of digit 2 -> outputs go off the next cycle; on re-raise, 2 blank cycles then digit 0, with no frame_done until a full frame completes.
REQ-038 Test: assert reset during DRIVE of digit 1 after a load -> an=1111 immediately; after release the display shows 0000 and pending is cleared (no stale update at the next boundary).
